sample_feeder: RTL and testbench

SAMPLE_FEEDER -- requirements
Module: sample_feeder

---
 rtl/sample_feeder_pkg.sv | 21 ++
 rtl/sample_fifo.sv | 72 +++++++
 rtl/sample_feeder.sv | 139 +++++++++++++
 tb/tb_sample_feeder.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sample_feeder_pkg.sv
// ---------------------------------------------------------------------------
// sample_feeder_pkg
// Shared definitions for the filter front end: the default sample width,
// the feeder FSM state encodings and the minimum spacing between filter
// start pulses.
// ---------------------------------------------------------------------------
package sample_feeder_pkg;

    // Default converter sample width
    localparam int DATA_SIZE_DEF = 24;

    // Feeder FSM state encodings
    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_TRIG      = 2'd1;
    localparam logic [1:0] ST_WAIT_DONE = 2'd2;
    localparam logic [1:0] ST_HOLD      = 2'd3;

    // Minimum number of cycles between consecutive sample_trig pulses
    localparam int TRIG_GAP = 5;

endpackage

// File: rtl/sample_fifo.sv
// ---------------------------------------------------------------------------
// sample_fifo
// Sample buffer between the converter and the feeder FSM. Writes are
// synchronous; the oldest entry is always visible on head and is removed
// by rd_en, with the consumer registering head on the same edge.
// Storage is not reset; only pointers and occupancy are.
//
// Ports
//   clk      in   clock
//   reset    in   synchronous, active-high reset
//   wr_en    in   write wr_data this cycle (ignored when full)
//   wr_data  in   DATA_SIZE sample to store
//   rd_en    in   pop the head entry this cycle (ignored when empty)
//   head     out  DATA_SIZE oldest stored sample
//   count    out  log2(FIFO_DEPTH)+1 current occupancy
// ---------------------------------------------------------------------------
module sample_fifo
    import sample_feeder_pkg::*;
#(
    parameter int DATA_SIZE  = DATA_SIZE_DEF,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        wr_en,
    input  logic [DATA_SIZE-1:0]        wr_data,
    input  logic                        rd_en,
    output logic [DATA_SIZE-1:0]        head,
    output logic [$clog2(FIFO_DEPTH):0] count
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0] FULL_LVL = (PTR_W+1)'(FIFO_DEPTH);

    logic [DATA_SIZE-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic                 do_wr;
    logic                 do_rd;

    assign do_wr = wr_en && (count != FULL_LVL);
    assign do_rd = rd_en && (count != '0);
    assign head  = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Depth is a power of two, so the pointers wrap by plain overflow
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_wr, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/sample_feeder.sv
// ---------------------------------------------------------------------------
// sample_feeder
// Buffers converter samples and hands them one at a time to the filter
// section: pops a sample into data_out (offset-binary converted when
// SIGNED_IN=1), pulses sample_trig, waits for filter_done (bounded by
// TIMEOUT), holds one more cycle for the filter's last stage, then repeats.
//
// Ports
//   clk          in   clock
//   reset        in   synchronous, active-high reset
//   adc_data     in   DATA_SIZE converter sample
//   adc_valid    in   adc_data valid this cycle
//   adc_ready    out  buffer can accept a sample
//   data_out     out  DATA_SIZE sample presented to the filter section
//   sample_trig  out  one-cycle start pulse to the filter section
//   filter_done  in   filter section result-ready pulse
//   overflow     out  sticky: a sample was dropped on a full buffer
//   timeout_err  out  sticky: filter_done did not arrive in time
//   fill_level   out  log2(FIFO_DEPTH)+1 current buffer occupancy
// ---------------------------------------------------------------------------
module sample_feeder
    import sample_feeder_pkg::*;
#(
    parameter int DATA_SIZE  = DATA_SIZE_DEF,
    parameter int FIFO_DEPTH = 8,
    parameter int SIGNED_IN  = 1,
    parameter int TIMEOUT    = 15
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [DATA_SIZE-1:0]        adc_data,
    input  logic                        adc_valid,
    output logic                        adc_ready,
    output logic [DATA_SIZE-1:0]        data_out,
    output logic                        sample_trig,
    input  logic                        filter_done,
    output logic                        overflow,
    output logic                        timeout_err,
    output logic [$clog2(FIFO_DEPTH):0] fill_level
);

    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [2:0]       GAP_MIN  = 3'(TRIG_GAP - 1);

    logic [1:0]           state;
    logic [1:0]           state_nxt;
    logic [CNT_W-1:0]     wait_cnt;
    logic [2:0]           gap;
    logic [DATA_SIZE-1:0] head;
    logic                 wr_en;
    logic                 pop;
    logic                 timeout_hit;

    // Two's-complement to offset binary is an MSB flip
    function automatic logic [DATA_SIZE-1:0] to_offset(input logic [DATA_SIZE-1:0] s);
        if (SIGNED_IN != 0) begin
            return {~s[DATA_SIZE-1], s[DATA_SIZE-2:0]};
        end
        return s;
    endfunction

    sample_fifo #(
        .DATA_SIZE  (DATA_SIZE),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_en),
        .wr_data (adc_data),
        .rd_en   (pop),
        .head    (head),
        .count   (fill_level)
    );

    // Readiness comes from registered occupancy only, so a pop in the same
    // cycle never opens room for a write on a full buffer.
    assign adc_ready = (fill_level < FULL_LVL);
    assign wr_en     = adc_valid && adc_ready;

    // gap counts cycles since the last trig. A filter that answers one
    // cycle after the trig would otherwise allow a 4-cycle trig spacing;
    // IDLE waits until the gap guarantees TRIG_GAP.
    assign pop = (state == ST_IDLE) && (fill_level != '0) && (gap >= GAP_MIN);

    // Done has priority over the timeout in the last allowed cycle
    assign timeout_hit = (state == ST_WAIT_DONE) && !filter_done && (wait_cnt == CNT_LAST);

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:      if (pop) state_nxt = ST_TRIG;
            ST_TRIG:      state_nxt = ST_WAIT_DONE;
            ST_WAIT_DONE: begin
                if (filter_done) begin
                    state_nxt = ST_HOLD;
                end else if (timeout_hit) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_HOLD:      state_nxt = ST_IDLE;
            default:      state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            wait_cnt    <= '0;
            gap         <= '1;
            sample_trig <= 1'b0;
            overflow    <= 1'b0;
            timeout_err <= 1'b0;
            data_out    <= '0;
        end else begin
            state       <= state_nxt;
            sample_trig <= (state_nxt == ST_TRIG);
            wait_cnt    <= (state == ST_WAIT_DONE) ? wait_cnt + 1'b1 : '0;
            if (sample_trig) begin
                gap <= 3'd1;
            end else if (gap != 3'd7) begin
                gap <= gap + 1'b1;
            end
            if (adc_valid && !adc_ready) begin
                overflow <= 1'b1;
            end
            if (timeout_hit) begin
                timeout_err <= 1'b1;
            end
            if (pop) begin
                data_out <= to_offset(head);
            end
        end
    end

endmodule

// File: tb/tb_sample_feeder.sv
module tb_sample_feeder;

    localparam int DATA_SIZE  = 24;
    localparam int FIFO_DEPTH = 8;
    localparam int SIGNED_IN  = 1;
    localparam int TIMEOUT    = 15;
    localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [DATA_SIZE-1:0] adc_data;
    logic                 adc_valid;
    logic                 adc_ready;
    logic [DATA_SIZE-1:0] data_out;
    logic                 sample_trig;
    logic                 filter_done;
    logic                 overflow;
    logic                 timeout_err;
    logic [LVL_W-1:0]     fill_level;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [DATA_SIZE-1:0] data;
        int                   w;
    } samp_t;

    sample_feeder #(
        .DATA_SIZE  (DATA_SIZE),
        .FIFO_DEPTH (FIFO_DEPTH),
        .SIGNED_IN  (SIGNED_IN),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .adc_data    (adc_data),
        .adc_valid   (adc_valid),
        .adc_ready   (adc_ready),
        .data_out    (data_out),
        .sample_trig (sample_trig),
        .filter_done (filter_done),
        .overflow    (overflow),
        .timeout_err (timeout_err),
        .fill_level  (fill_level)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    // Offset binary: add half scale modulo 2^DATA_SIZE
    function automatic logic [DATA_SIZE-1:0] expect_out(input logic [DATA_SIZE-1:0] s);
        logic [DATA_SIZE-1:0] half;
        if (SIGNED_IN == 0) return s;
        half = '0;
        half[DATA_SIZE-1] = 1'b1;
        return s + half;
    endfunction

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Leaves the caller at a falling edge with reset released (cycle 0)
    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; adc_valid = 1'b0; adc_data = '0; filter_done = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; adc_valid = 1'b1; adc_data = '1; filter_done = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (sample_trig !== 1'b0) begin errors++; $display("FAIL reset_trig got %0b want 0", sample_trig); end
        checks++; if (data_out !== '0) begin errors++; $display("FAIL reset_data got %h want 0", data_out); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got %0b want 0", overflow); end
        checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL reset_tmo got %0b want 0", timeout_err); end
        checks++; if (fill_level !== '0) begin errors++; $display("FAIL reset_fill got %0d want 0", fill_level); end
        checks++; if (adc_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %0b want 1", adc_ready); end
        reset = 1'b0; adc_valid = 1'b0; filter_done = 1'b0;
    endtask

    task automatic test_single();
        do_reset();
        adc_valid = 1'b1; adc_data = 24'h000001;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            adc_valid   = 1'b0;
            filter_done = (c == 4);
            checks++;
            if (sample_trig !== (c == 2)) begin
                errors++; $display("FAIL single_trig cycle %0d got %0b want %0b", c, sample_trig, (c == 2));
            end
            if (c >= 2 && c <= 5) begin
                checks++;
                if (data_out !== 24'h800001) begin
                    errors++; $display("FAIL single_data cycle %0d got %h want 800001", c, data_out);
                end
            end
        end
        filter_done = 1'b0;
    endtask

    task automatic test_burst();
        logic [DATA_SIZE-1:0] vals [8];
        int ntrig;
        int done_at;
        ntrig = 0; done_at = -1;
        for (int i = 0; i < 8; i++) vals[i] = DATA_SIZE'($urandom);
        do_reset();
        for (int c = 0; c < 50; c++) begin
            if (c > 0) @(negedge clk);
            if (sample_trig === 1'b1) begin
                checks++;
                if (ntrig >= 8) begin
                    errors++; $display("FAIL burst_extra_trig cycle %0d got %0d trigs want 8", c, ntrig + 1);
                end else begin
                    if (c != 2 + 5 * ntrig) begin
                        errors++; $display("FAIL burst_time trig %0d got cycle %0d want %0d", ntrig, c, 2 + 5 * ntrig);
                    end
                    checks++;
                    if (data_out !== expect_out(vals[ntrig])) begin
                        errors++; $display("FAIL burst_data trig %0d got %h want %h", ntrig, data_out, expect_out(vals[ntrig]));
                    end
                end
                ntrig++;
                done_at = c + 2;
            end
            filter_done = (c == done_at);
            adc_valid   = (c < 8);
            if (c < 8) adc_data = vals[c];
        end
        adc_valid = 1'b0; filter_done = 1'b0;
        checks++; if (ntrig != 8) begin errors++; $display("FAIL burst_count got %0d want 8", ntrig); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL burst_ovf got %0b want 0", overflow); end
    endtask

    task automatic test_full();
        int exp_fill;
        do_reset();
        for (int c = 0; c <= 12; c++) begin
            if (c > 0) @(negedge clk);
            // First sample leaves for the filter after one cycle; the stalled
            // filter then keeps everything else in the buffer.
            exp_fill = (c <= 1) ? c : imax(0, (c - 1 > FIFO_DEPTH) ? FIFO_DEPTH : c - 1);
            checks++;
            if (fill_level !== LVL_W'(exp_fill)) begin
                errors++; $display("FAIL full_fill cycle %0d got %0d want %0d", c, fill_level, exp_fill);
            end
            checks++;
            if (adc_ready !== (exp_fill < FIFO_DEPTH)) begin
                errors++; $display("FAIL full_ready cycle %0d got %0b want %0b", c, adc_ready, (exp_fill < FIFO_DEPTH));
            end
            adc_valid = (c < 12);
            adc_data  = DATA_SIZE'($urandom);
        end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL full_ovf got %0b want 1", overflow); end
        adc_valid = 1'b0;
    endtask

    task automatic test_timeout();
        logic [DATA_SIZE-1:0] b;
        b = DATA_SIZE'($urandom);
        do_reset();
        for (int c = 0; c <= 20; c++) begin
            if (c > 0) begin
                @(negedge clk);
                checks++;
                if (sample_trig !== (c == 2 || c == 19)) begin
                    errors++; $display("FAIL tmo_trig cycle %0d got %0b want %0b", c, sample_trig, (c == 2 || c == 19));
                end
                checks++;
                if (timeout_err !== (c >= 18)) begin
                    errors++; $display("FAIL tmo_flag cycle %0d got %0b want %0b", c, timeout_err, (c >= 18));
                end
                if (c == 19) begin
                    checks++;
                    if (data_out !== expect_out(b)) begin
                        errors++; $display("FAIL tmo_next_data got %h want %h", data_out, expect_out(b));
                    end
                end
            end
            adc_valid = (c <= 1);
            adc_data  = (c == 0) ? DATA_SIZE'($urandom) : b;
        end
        adc_valid = 1'b0;
    endtask

    task automatic test_stray_done();
        do_reset();
        for (int c = 0; c <= 24; c++) begin
            if (c > 0) begin
                @(negedge clk);
                checks++;
                if (sample_trig !== (c == 6 || c == 23)) begin
                    errors++; $display("FAIL stray_trig cycle %0d got %0b want %0b", c, sample_trig, (c == 6 || c == 23));
                end
                checks++;
                if (timeout_err !== (c >= 22)) begin
                    errors++; $display("FAIL stray_tmo cycle %0d got %0b want %0b", c, timeout_err, (c >= 22));
                end
                if (c <= 4) begin
                    checks++;
                    if (fill_level !== '0) begin
                        errors++; $display("FAIL stray_fill cycle %0d got %0d want 0", c, fill_level);
                    end
                end
            end
            // done while idle-empty (0), idle-popping (5) and in the trig cycle (6)
            filter_done = (c == 0 || c == 5 || c == 6);
            adc_valid   = (c == 4 || c == 5);
            adc_data    = DATA_SIZE'($urandom);
        end
        adc_valid = 1'b0; filter_done = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int c = 0; c <= 18; c++) begin
            if (c > 0) @(negedge clk);
            if (c == 11) begin
                checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL rmid_pre_ovf got %0b want 1", overflow); end
                checks++; if (fill_level !== LVL_W'(FIFO_DEPTH)) begin errors++; $display("FAIL rmid_pre_fill got %0d want %0d", fill_level, FIFO_DEPTH); end
            end
            if (c == 12) begin
                checks++; if (data_out !== '0) begin errors++; $display("FAIL rmid_data got %h want 0", data_out); end
                checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rmid_ovf got %0b want 0", overflow); end
                checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL rmid_tmo got %0b want 0", timeout_err); end
                checks++; if (adc_ready !== 1'b1) begin errors++; $display("FAIL rmid_ready got %0b want 1", adc_ready); end
            end
            if (c >= 12) begin
                checks++; if (sample_trig !== 1'b0) begin errors++; $display("FAIL rmid_trig cycle %0d got %0b want 0", c, sample_trig); end
                checks++; if (fill_level !== '0) begin errors++; $display("FAIL rmid_fill cycle %0d got %0d want 0", c, fill_level); end
            end
            adc_valid = (c <= 10);
            adc_data  = DATA_SIZE'($urandom);
            reset     = (c == 11);
        end
        reset = 1'b0; adc_valid = 1'b0;
    endtask

    // Transaction-level model: a queue of accepted samples with their write
    // cycle, and the earliest cycle the feeder may start its next sample.
    task automatic test_random();
        samp_t                q[$];
        int                   free_time, done_at, to_at, d;
        logic                 exp_ovf, exp_to, ovf_pend, trig_exp;
        logic [DATA_SIZE-1:0] exp_dout;
        free_time = 0; done_at = -1; to_at = -1;
        exp_ovf = 1'b0; exp_to = 1'b0; ovf_pend = 1'b0; exp_dout = '0;
        do_reset();
        for (int c = 0; c < 1600; c++) begin
            if (c > 0) @(negedge clk);
            if (ovf_pend) exp_ovf = 1'b1;
            if (c == to_at) exp_to = 1'b1;
            trig_exp = (q.size() > 0) && (c == imax(free_time, q[0].w + 2));
            checks++;
            if (sample_trig !== trig_exp) begin
                errors++; $display("FAIL rand_trig cycle %0d got %0b want %0b", c, sample_trig, trig_exp);
            end
            if (trig_exp) begin
                exp_dout = expect_out(q[0].data);
                void'(q.pop_front());
                if ($urandom_range(9) == 0) begin
                    done_at   = -1;
                    to_at     = c + TIMEOUT + 1;
                    free_time = c + TIMEOUT + 2;
                end else begin
                    d         = int'($urandom_range(TIMEOUT, 1));
                    done_at   = c + d;
                    free_time = imax(c + d + 3, c + 5);
                end
            end
            checks++;
            if (data_out !== exp_dout) begin
                errors++; $display("FAIL rand_data cycle %0d got %h want %h", c, data_out, exp_dout);
            end
            checks++;
            if (fill_level !== LVL_W'(q.size())) begin
                errors++; $display("FAIL rand_fill cycle %0d got %0d want %0d", c, fill_level, q.size());
            end
            checks++;
            if (adc_ready !== (q.size() < FIFO_DEPTH)) begin
                errors++; $display("FAIL rand_ready cycle %0d got %0b want %0b", c, adc_ready, (q.size() < FIFO_DEPTH));
            end
            checks++;
            if (overflow !== exp_ovf) begin
                errors++; $display("FAIL rand_ovf cycle %0d got %0b want %0b", c, overflow, exp_ovf);
            end
            checks++;
            if (timeout_err !== exp_to) begin
                errors++; $display("FAIL rand_tmo cycle %0d got %0b want %0b", c, timeout_err, exp_to);
            end
            filter_done = (c == done_at);
            adc_valid   = (c < 1400) && ($urandom_range(99) < ((c < 600) ? 8 : 50));
            adc_data    = DATA_SIZE'($urandom);
            ovf_pend    = 1'b0;
            if (adc_valid) begin
                if (q.size() < FIFO_DEPTH) q.push_back('{adc_data, c});
                else ovf_pend = 1'b1;
            end
        end
        adc_valid = 1'b0; filter_done = 1'b0;
    endtask

    initial begin
        reset = 1'b1; adc_valid = 1'b0; adc_data = '0; filter_done = 1'b0;
        test_reset();
        test_single();
        test_burst();
        test_full();
        test_timeout();
        test_stray_done();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
